// File: rtl/hazard_unit_if.sv
// hazard_unit_if -- bundle between the datapath pipeline registers and the
// hazard/stall controller.
//   master : datapath side; drives register indices and control bits, and
//            receives stall/flush/forward controls.
//   slave  : hazard unit side; the mirror image of master.
// Signals:
//   Rs1D/Rs2D, Rs1E/Rs2E      source indices in decode and execute
//   RdE/RdM/RdW               destination indices in E, M, W
//   regWriteM/regWriteW       register-write enables in M, W
//   resultSrcE                result select in E (2'b01 = load)
//   pcSrcE                    taken branch/jump resolved in E
//   memReqM                   load/store occupying M
//   stallF..stallW            hold PC and pipeline registers
//   flushD/flushE             bubble the D or E register
//   forwardAE/forwardBE       operand selects into execute
//   busy                      memory wait FSM not idle
//   stallCount                memory-stall cycles since reset (wraps)
interface hazard_unit_if;
   logic [3:0]  Rs1D;
   logic [3:0]  Rs2D;
   logic [3:0]  Rs1E;
   logic [3:0]  Rs2E;
   logic [3:0]  RdE;
   logic [3:0]  RdM;
   logic [3:0]  RdW;
   logic        regWriteM;
   logic        regWriteW;
   logic [1:0]  resultSrcE;
   logic        pcSrcE;
   logic        memReqM;
   logic        stallF;
   logic        stallD;
   logic        stallE;
   logic        stallM;
   logic        stallW;
   logic        flushD;
   logic        flushE;
   logic [1:0]  forwardAE;
   logic [1:0]  forwardBE;
   logic        busy;
   logic [15:0] stallCount;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output regWriteM, regWriteW, resultSrcE, pcSrcE, memReqM,
      input  stallF, stallD, stallE, stallM, stallW, flushD, flushE,
      input  forwardAE, forwardBE, busy, stallCount
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  regWriteM, regWriteW, resultSrcE, pcSrcE, memReqM,
      output stallF, stallD, stallE, stallM, stallW, flushD, flushE,
      output forwardAE, forwardBE, busy, stallCount
   );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit -- pipeline hazard and stall controller for the 16-bit
// five-stage core. Produces operand-forwarding selects, load-use and
// control-transfer stall/flush, and sequences multi-cycle data-memory
// accesses with a small wait FSM.
// Parameters:
//   MEM_LAT  data-memory latency in cycles (1..16); 1 = no memory stall.
// Ports:
//   clk      core clock, rising edge
//   rst      synchronous active-high reset
//   hz       hazard_unit_if.slave bundle (see interface header)
// Stall/flush/forward responses are combinational so they act in the same
// cycle as the hazard; only the wait FSM and the stall counter are state.
module hazard_unit #(
   parameter int MEM_LAT = 1
) (
   input logic           clk,
   input logic           rst,
   hazard_unit_if.slave  hz
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   // A single-cycle memory never needs the FSM.
   localparam logic       LONG_ACCESS = (MEM_LAT > 1);
   // WAIT spends cnt+1 cycles, IDLE one more: MEM_LAT-1 stalled cycles total.
   localparam logic [3:0] CNT_LOAD    = 4'(MEM_LAT - 2);

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic [15:0] stall_count_r;

   logic        mem_stall_s;
   logic        lw_stall_s;
   logic        stall_f_s;
   logic        stall_d_s;
   logic        stall_e_s;
   logic        stall_m_s;
   logic        stall_w_s;
   logic        flush_d_s;
   logic        flush_e_s;
   logic [1:0]  forward_a_s;
   logic [1:0]  forward_b_s;
   logic        busy_s;

   // Memory stage wins over writeback; register 0 is forwarded like any other.
   function automatic logic [1:0] fwd_sel(
      input logic [3:0] rs,
      input logic       reg_write_m,
      input logic [3:0] rd_m,
      input logic       reg_write_w,
      input logic [3:0] rd_w
   );
      logic [1:0] sel;
      if (reg_write_m && (rd_m == rs)) begin
         sel = 2'b10;
      end else if (reg_write_w && (rd_w == rs)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Memory stall depends on the FSM state and, in IDLE, on the new request.
   always_comb begin
      mem_stall_s = 1'b0;
      if (rst) begin
         mem_stall_s = 1'b0;
      end else begin
         case (state_r)
            IDLE:    mem_stall_s = LONG_ACCESS && hz.memReqM;
            WAIT:    mem_stall_s = (cnt_r != 4'd0);
            default: mem_stall_s = 1'b0;
         endcase
      end
   end

   // Stall/flush priority: memory stall, then redirect, then load-use.
   always_comb begin
      stall_f_s   = 1'b0;
      stall_d_s   = 1'b0;
      stall_e_s   = 1'b0;
      stall_m_s   = 1'b0;
      stall_w_s   = 1'b0;
      flush_d_s   = 1'b0;
      flush_e_s   = 1'b0;
      forward_a_s = 2'b00;
      forward_b_s = 2'b00;
      busy_s      = 1'b0;
      lw_stall_s  = (hz.resultSrcE == 2'b01) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
      if (rst) begin
         lw_stall_s = 1'b0;
      end else begin
         forward_a_s = fwd_sel(hz.Rs1E, hz.regWriteM, hz.RdM, hz.regWriteW, hz.RdW);
         forward_b_s = fwd_sel(hz.Rs2E, hz.regWriteM, hz.RdM, hz.regWriteW, hz.RdW);
         busy_s      = (state_r == WAIT);
         if (mem_stall_s) begin
            // Freeze everything; a pending redirect is honoured on release.
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
            stall_w_s = 1'b1;
         end else if (hz.pcSrcE) begin
            // Let the redirect target be fetched even if a load-use is pending.
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
         end else if (lw_stall_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
         end else begin
            flush_d_s = 1'b0;
         end
      end
   end

   // Memory wait FSM and stall-cycle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         cnt_r         <= 4'd0;
         stall_count_r <= 16'd0;
      end else begin
         if (mem_stall_s) begin
            stall_count_r <= stall_count_r + 16'd1;
         end
         case (state_r)
            IDLE: begin
               if (LONG_ACCESS && hz.memReqM) begin
                  state_r <= WAIT;
                  cnt_r   <= CNT_LOAD;
               end
            end
            WAIT: begin
               if (cnt_r != 4'd0) begin
                  cnt_r <= cnt_r - 4'd1;
               end else begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= 4'd0;
            end
         endcase
      end
   end

   assign hz.stallF     = stall_f_s;
   assign hz.stallD     = stall_d_s;
   assign hz.stallE     = stall_e_s;
   assign hz.stallM     = stall_m_s;
   assign hz.stallW     = stall_w_s;
   assign hz.flushD     = flush_d_s;
   assign hz.flushE     = flush_e_s;
   assign hz.forwardAE  = forward_a_s;
   assign hz.forwardBE  = forward_b_s;
   assign hz.busy       = busy_s;
   assign hz.stallCount = stall_count_r;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall controller for the 16-bit five-stage core (fetch, decode, execute, memory, writeback). It drives the operand-forwarding selects into execute and the stall/flush enables of every pipeline register. It detects load-use and taken-branch/jump hazards, and sequences multi-cycle data-memory accesses with an internal wait FSM. It sits beside the datapath and takes register indices and control bits from the decode, execute, memory and writeback pipeline registers.

## Interface

- MEM_LAT, default 1: data-memory access latency in cycles, legal range 1..16; 1 means no memory stall.
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Rs1D, Rs2D  input  4  source register indices of the instruction in decode.
- Rs1E, Rs2E  input  4  source register indices of the instruction in execute.
- RdE, RdM, RdW  input  4  destination indices in execute, memory and writeback.
- regWriteM, regWriteW  input  1  register-write enables in memory and writeback.
- resultSrcE  input  2  result select in execute; 2'b01 marks a load.
- pcSrcE  input  1  taken branch or jump resolved in execute.
- memReqM  input  1  load or store occupying the memory stage.
- stallF, stallD, stallE, stallM, stallW  output  1  hold the PC and the decode/execute/memory/writeback registers.
- flushD, flushE  output  1  clear the decode or execute register to a bubble (all control bits 0).
- forwardAE, forwardBE  output  2  operand select: 00 register file, 01 resultW, 10 ALU result in memory.
- busy  output  1  memory wait FSM is not idle.
- stallCount  output  16  count of memory-stall cycles since reset; wraps modulo 2^16.

## Operation

- **Forwarding (combinational).** forwardAE = 10 if regWriteM and RdM==Rs1E; else 01 if regWriteW and RdW==Rs1E; else 00.
  - forwardBE uses the same rule on Rs2E.
  - The memory stage has priority over writeback.
  - All 16 registers are eligible.
- **Load-use (lwStall).** lwStall = (resultSrcE==01) and (RdE==Rs1D or RdE==Rs2D).
  - Effect: stallF=1, stallD=1, flushE=1.
- **Taken control transfer.** pcSrcE=1 gives flushD=1 and flushE=1.
  - It overrides lwStall: stallF=0 and stallD=0, so the redirect target is fetched.
- **Memory wait FSM.** States IDLE and WAIT; a 4-bit down-counter cnt.
  - IDLE with memReqM=1 and MEM_LAT>1: memStall=1, go to WAIT, cnt <= MEM_LAT-2.
  - WAIT with cnt!=0: memStall=1, cnt <= cnt-1.
  - WAIT with cnt==0: memStall=0, return to IDLE.
  - The access therefore occupies M for exactly MEM_LAT cycles.
  - A new memReqM arriving in IDLE right after the return starts a fresh access.
  - memStall=1 gives stallF=stallD=stallE=stallM=stallW=1.
  - memStall=1 forces flushD=0 and flushE=0 and masks lwStall and pcSrcE. Held stages keep their control, so a pending pcSrcE takes effect in the release cycle.
  - Holding writeback repeats its (idempotent) register write, so W-stage forwarding stays valid.
- busy = (state==WAIT).
- stallCount increments on each cycle with memStall=1.
- Priority order: memStall > pcSrcE > lwStall > forwarding.

## Timing

- Reset (rst=1 at an edge): state <= IDLE, cnt <= 0, stallCount <= 0.
- While rst=1, all stall and flush outputs are 0, forward selects are 00 and busy is 0; memReqM is ignored.
- Reset asserted mid-WAIT abandons the access; the FSM is IDLE on the next cycle.
- Forwarding, lwStall and pcSrcE responses are same-cycle combinational (zero latency).
- Load-use costs one bubble: stall is asserted in the one cycle the load sits in E.
- Memory stall: with memReqM rising in cycle t, memStall is high in cycles t .. t+MEM_LAT-2 and low in t+MEM_LAT-1.
- busy is high in cycles t+1 .. t+MEM_LAT-1.
- stallCount reflects a stall cycle one cycle after that cycle.
- MEM_LAT=1: the FSM never leaves IDLE and memStall stays 0.
- stallCount wraps from 16'hFFFF to 16'h0000.

## Test plan

- **Forwarding priority.** regWriteM=1, RdM=3, regWriteW=1, RdW=3, Rs1E=3, Rs2E=3 -> forwardAE=forwardBE=10. Then regWriteM=0 -> both 01. Then Rs1E=4 -> forwardAE=00.
- **Load-use.** resultSrcE=01, RdE=5, Rs2D=5, pcSrcE=0 -> stallF=stallD=flushE=1, flushD=0. Then RdE=6 -> all 0.
- **Branch overrides load-use.** pcSrcE=1 together with the load-use condition above -> flushD=flushE=1, stallF=stallD=0.
- **Memory wait, MEM_LAT=4.** memReqM held high from cycle t:
  - stall outputs are 1 for cycles t..t+2 and 0 at t+3;
  - busy is 1 for cycles t+1..t+3;
  - stallCount reads 3 at t+4.
  - Back-to-back requests restart the sequence.
- **Branch during memory wait.** pcSrcE=1 throughout the memory-wait case -> flushD=flushE=0 while stalled, flushD=flushE=1 in the release cycle.
- **Reset mid-wait.** Assert rst in cycle t+1 of a MEM_LAT=8 access -> next cycle busy=0, stallCount=0, all stalls 0. Assert MEM_LAT=1 -> no stall for any memReqM.
